// File: rtl/comma_align_pkg.sv
// comma_align_pkg: comma patterns, K28.5 code-groups and FSM encoding shared by the aligner
package comma_align_pkg;
  localparam logic [6:0] COMMA_P = 7'b0011111;
  localparam logic [6:0] COMMA_N = 7'b1100000;
  localparam logic [9:0] K28_5_N = 10'b0011111010;
  localparam logic [9:0] K28_5_P = 10'b1100000101;
  typedef enum logic [1:0] {
    LOSS   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;
  function automatic logic is_comma(input logic [6:0] w);
    return (w == COMMA_P) || (w == COMMA_N);
  endfunction
endpackage

// File: rtl/comma_detect.sv
// comma_detect: flags a comma in each of the ten 10-bit windows of the history and picks the lowest hit
module comma_detect
  import comma_align_pkg::*;
(
  input  logic [19:0] hist_i,
  output logic [9:0]  hit_o,
  output logic        any_o,
  output logic [3:0]  off_o
);
  for (genvar k = 0; k < 10; k++) begin : g_win
    assign hit_o[k] = is_comma(hist_i[19-k -: 7]);
  end
  assign any_o = |hit_o;
  // scan from the top down so the smallest hitting offset is the one left standing
  always_comb begin
    off_o = '0;
    for (int i = 9; i >= 0; i--) off_o = hit_o[i] ? 4'(i) : off_o;
  end
endmodule

// File: rtl/comma_align.sv
// comma_align: finds the K28.5 comma offset in the raw 10b stream, locks to it and emits aligned code-groups
module comma_align
  import comma_align_pkg::*;
#(
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] raw_10b,
  output logic [9:0] data_10b,
  output logic       comma,
  output logic       rx_sync,
  output logic [3:0] align_offset
);
  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_CNT + 1);
  localparam logic [CW-1:0] LOCK_V   = CW'(LOCK_CNT);
  localparam logic [MW-1:0] UNLOCK_V = MW'(UNLOCK_CNT);
  state_e        state_q, state_d;
  logic [9:0]    prev_q, data_q, win, hit;
  logic [19:0]   hist;
  logic [3:0]    off_q, off_d, cand_q, cand_d, hit_off;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MW-1:0] miss_q, miss_d, miss_inc;
  logic          comma_q, sync_q, any_hit;
  assign hist     = {prev_q, raw_10b};
  assign win      = hist[5'd19 - 5'(off_q) -: 10];
  assign cnt_inc  = (cnt_q == LOCK_V) ? cnt_q : cnt_q + 1'b1;
  assign miss_inc = (miss_q == UNLOCK_V) ? miss_q : miss_q + 1'b1;
  comma_detect u_det (
    .hist_i(hist),
    .hit_o (hit),
    .any_o (any_hit),
    .off_o (hit_off)
  );
  // acquisition/lock FSM: count same-offset commas to lock, foreign-only commas to drop lock
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    unique case (state_q)
      LOSS: if (any_hit) begin
        cand_d  = hit_off;
        cnt_d   = CW'(1);
        state_d = ACQ;
      end
      ACQ: if (hit[cand_q]) begin
        cnt_d = cnt_inc;
        if (cnt_inc == LOCK_V) begin
          off_d   = cand_q;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end else if (any_hit) begin
        cand_d = hit_off;
        cnt_d  = CW'(1);
      end
      LOCKED: if (hit[off_q]) begin
        miss_d = '0;
      end else if (any_hit) begin
        miss_d = miss_inc;
        if (miss_inc == UNLOCK_V) begin
          miss_d  = '0;
          cand_d  = hit_off;
          cnt_d   = CW'(1);
          state_d = ACQ;
        end
      end
      default: state_d = LOSS;
    endcase
  end
  // state, history and registered aligned outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOSS;
      prev_q  <= '0;
      off_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
      data_q  <= '0;
      comma_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= raw_10b;
      off_q   <= off_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      data_q  <= win;
      comma_q <= hit[off_q];
      sync_q  <= (state_q == LOCKED);
    end
  end
  assign data_10b     = data_q;
  assign comma        = comma_q;
  assign rx_sync      = sync_q;
  assign align_offset = off_q;
endmodule

// File: tb/tb_comma_align.sv
// tb_comma_align: directed scenarios for comma alignment, lock, restart, unlock and reset
module tb_comma_align;
  import comma_align_pkg::*;
  localparam logic [9:0] FIL = 10'b0101010101;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] raw;
  logic [9:0] data_10b;
  logic       comma;
  logic       rx_sync;
  logic [3:0] align_offset;
  logic [9:0] gen_prev, sent_prev;
  logic       kpol;
  int         n_run, n_fail;

  always #5 clk = ~clk;

  comma_align dut (
    .clk         (clk),
    .reset       (reset),
    .raw_10b     (raw),
    .data_10b    (data_10b),
    .comma       (comma),
    .rx_sync     (rx_sync),
    .align_offset(align_offset)
  );

  task automatic send(input logic [9:0] sym, input int k);
    logic [19:0] pair;
    pair      = {gen_prev, sym} >> k;
    raw       = pair[9:0];
    sent_prev = gen_prev;
    gen_prev  = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic send_k(input int k);
    send(kpol ? K28_5_P : K28_5_N, k);
    kpol = ~kpol;
  endtask

  task automatic send_f(input int k);
    send(FIL, k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    raw   = K28_5_N;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    gen_prev = FIL;
    kpol     = 1'b0;
  endtask

  task automatic lock_at(input int k);
    send_f(k);
    send_f(k);
    repeat (4) send_k(k);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    raw   = K28_5_P;
    repeat (2) @(posedge clk);
    #1;
    n_run++; if (data_10b !== 10'd0) begin n_fail++; $display("FAIL reset_data: got %h want 000", data_10b); end
    n_run++; if (comma !== 1'b0) begin n_fail++; $display("FAIL reset_comma: got %b want 0", comma); end
    n_run++; if (rx_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", rx_sync); end
    n_run++; if (align_offset !== 4'd0) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", align_offset); end
    n_run++; if (dut.state_q !== LOSS) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, LOSS); end
    n_run++; if (dut.prev_q !== 10'd0) begin n_fail++; $display("FAIL reset_prev: got %h want 000", dut.prev_q); end
    n_run++; if ({dut.cand_q, dut.cnt_q, dut.miss_q} !== '0) begin n_fail++; $display("FAIL reset_counters: got cand %0d cnt %0d miss %0d want 0", dut.cand_q, dut.cnt_q, dut.miss_q); end
    reset = 1'b0;
  endtask

  task automatic test_lock_offset0();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 2) send_f(0); else send_k(0);
      if (i >= 1) begin
        n_run++; if (data_10b !== sent_prev) begin n_fail++; $display("FAIL off0_data[%0d]: got %h want %h", i, data_10b, sent_prev); end
      end
      n_run++; if (rx_sync !== (i >= 6)) begin n_fail++; $display("FAIL off0_sync[%0d]: got %b want %b", i, rx_sync, i >= 6); end
      n_run++; if (comma !== (i >= 3)) begin n_fail++; $display("FAIL off0_comma[%0d]: got %b want %b", i, comma, i >= 3); end
    end
    n_run++; if (align_offset !== 4'd0) begin n_fail++; $display("FAIL off0_offset: got %0d want 0", align_offset); end
  endtask

  task automatic test_skew3();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 2) send_f(3); else send_k(3);
      n_run++; if (align_offset !== ((i >= 5) ? 4'd3 : 4'd0)) begin n_fail++; $display("FAIL skew3_offset[%0d]: got %0d want %0d", i, align_offset, (i >= 5) ? 3 : 0); end
      n_run++; if (rx_sync !== (i >= 6)) begin n_fail++; $display("FAIL skew3_sync[%0d]: got %b want %b", i, rx_sync, i >= 6); end
      if (i >= 6) begin
        n_run++; if (data_10b !== sent_prev) begin n_fail++; $display("FAIL skew3_data[%0d]: got %h want %h", i, data_10b, sent_prev); end
        n_run++; if (comma !== 1'b1) begin n_fail++; $display("FAIL skew3_comma[%0d]: got %b want 1", i, comma); end
      end
    end
  endtask

  task automatic test_acq_restart();
    do_reset();
    send_f(3);
    send_f(3);
    send_k(3);
    send_k(3);
    send_f(3);
    n_run++; if (dut.state_q !== ACQ || dut.cand_q !== 4'd3 || dut.cnt_q !== 2'd2) begin n_fail++; $display("FAIL restart_two_at3: got state %0d cand %0d cnt %0d want 1 3 2", dut.state_q, dut.cand_q, dut.cnt_q); end
    send_f(5);
    send_f(5);
    send_k(5);
    send_k(5);
    n_run++; if (dut.state_q !== ACQ || dut.cand_q !== 4'd5 || dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL restart_new_cand: got state %0d cand %0d cnt %0d want 1 5 1", dut.state_q, dut.cand_q, dut.cnt_q); end
    send_k(5);
    n_run++; if (rx_sync !== 1'b0 || dut.state_q !== ACQ) begin n_fail++; $display("FAIL restart_no_early_lock: got sync %b state %0d want 0 1", rx_sync, dut.state_q); end
    send_f(5);
    n_run++; if (dut.state_q !== LOCKED || align_offset !== 4'd5) begin n_fail++; $display("FAIL restart_lock5: got state %0d offset %0d want 2 5", dut.state_q, align_offset); end
    send_f(5);
    n_run++; if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL restart_sync: got %b want 1", rx_sync); end
  endtask

  task automatic test_unlock();
    do_reset();
    lock_at(3);
    send_f(3);
    send_f(6);
    send_f(6);
    repeat (4) send_k(6);
    n_run++; if (dut.state_q !== LOCKED || rx_sync !== 1'b1 || dut.miss_q !== 3'd3) begin n_fail++; $display("FAIL unlock_three_misses: got state %0d sync %b miss %0d want 2 1 3", dut.state_q, rx_sync, dut.miss_q); end
    send_f(6);
    n_run++; if (dut.state_q !== ACQ || dut.cand_q !== 4'd6 || dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL unlock_to_acq: got state %0d cand %0d cnt %0d want 1 6 1", dut.state_q, dut.cand_q, dut.cnt_q); end
    n_run++; if (align_offset !== 4'd3) begin n_fail++; $display("FAIL unlock_offset_held: got %0d want 3", align_offset); end
    send_f(6);
    n_run++; if (rx_sync !== 1'b0 || align_offset !== 4'd3) begin n_fail++; $display("FAIL unlock_sync_drop: got sync %b offset %0d want 0 3", rx_sync, align_offset); end
  endtask

  task automatic test_hold_lock();
    do_reset();
    lock_at(3);
    send_f(3);
    send_f(6);
    send_f(6);
    repeat (3) send_k(6);
    send_f(6);
    n_run++; if (dut.miss_q !== 3'd3 || rx_sync !== 1'b1) begin n_fail++; $display("FAIL hold_three_misses: got miss %0d sync %b want 3 1", dut.miss_q, rx_sync); end
    send_f(3);
    send_f(3);
    n_run++; if (dut.miss_q !== 3'd3 || dut.state_q !== LOCKED) begin n_fail++; $display("FAIL hold_idle_no_change: got miss %0d state %0d want 3 2", dut.miss_q, dut.state_q); end
    send_k(3);
    send_f(3);
    n_run++; if (dut.miss_q !== 3'd0 || rx_sync !== 1'b1 || align_offset !== 4'd3) begin n_fail++; $display("FAIL hold_miss_clear: got miss %0d sync %b offset %0d want 0 1 3", dut.miss_q, rx_sync, align_offset); end
  endtask

  task automatic test_reset_locked();
    do_reset();
    n_run++; if ({data_10b, comma, rx_sync, align_offset} !== '0 || dut.state_q !== LOSS) begin n_fail++; $display("FAIL rst_locked_outputs: got data %h comma %b sync %b offset %0d state %0d want 0", data_10b, comma, rx_sync, align_offset, dut.state_q); end
    send_f(3);
    send_f(3);
    repeat (3) send_k(3);
    n_run++; if (rx_sync !== 1'b0 || dut.state_q !== ACQ || dut.cnt_q !== 2'd2) begin n_fail++; $display("FAIL rst_relock_two: got sync %b state %0d cnt %0d want 0 1 2", rx_sync, dut.state_q, dut.cnt_q); end
    send_k(3);
    n_run++; if (dut.state_q !== LOCKED || align_offset !== 4'd3) begin n_fail++; $display("FAIL rst_relock: got state %0d offset %0d want 2 3", dut.state_q, align_offset); end
    send_f(3);
    n_run++; if (rx_sync !== 1'b1) begin n_fail++; $display("FAIL rst_relock_sync: got %b want 1", rx_sync); end
  endtask

  task automatic test_priority();
    do_reset();
    raw = 10'b1100000111;
    @(posedge clk);
    #1;
    raw = 10'b1100000000;
    @(posedge clk);
    #1;
    n_run++; if (dut.state_q !== ACQ || dut.cand_q !== 4'd0 || dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL priority_lowest: got state %0d cand %0d cnt %0d want 1 0 1", dut.state_q, dut.cand_q, dut.cnt_q); end
  endtask

  initial begin
    n_run    = 0;
    n_fail   = 0;
    gen_prev = FIL;
    kpol     = 1'b0;
    test_reset();
    test_lock_offset0();
    test_skew3();
    test_acq_restart();
    test_unlock();
    test_hold_lock();
    test_reset_locked();
    test_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/comma_align.md
COMMA_ALIGN -- requirements
Module: comma_align

Interface
REQ-001 Parameter LOCK_CNT, default 3: consecutive same-offset commas required to declare lock.
REQ-002 Parameter UNLOCK_CNT, default 4: consecutive commas at a foreign offset, with none at the locked offset, that cause loss of lock.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 raw_10b  input  10  unaligned deserialized word, one per clk; bit 9 is the earliest-received bit.
REQ-006 data_10b  output  10  aligned code-group (abcdei = [9:4], fghj = [3:0]), registered, feeds the 8b/10b decoder.
REQ-007 comma  output  1  registered; data_10b[9:3] equals 0011111 or 1100000.
REQ-008 rx_sync  output  1  registered; high while the FSM is in LOCKED.
REQ-009 align_offset  output  4  current bit offset, range 0..9.

Function
REQ-010 The history register shall hold the previous raw word (hist = {prev_raw, raw_10b}, 20 bits, bit 19 oldest).
REQ-011 Window k (k = 0..9) shall be hist[19-k : 10-k]; window 0 is exactly prev_raw.
REQ-012 A comma hit at offset k shall mean window k bits [9:3] equal 0011111 or 1100000.
REQ-013 If several offsets hit in one cycle, the lowest k shall be the detected offset (hit_off).
REQ-014 Each clk: data_10b <= window[align_offset]; comma <= hit at align_offset; rx_sync <= (state == LOCKED).
REQ-015 Latency at a fixed offset: a raw word at offset 0 shall appear on data_10b exactly 2 clks after it is presented on raw_10b.
REQ-016 FSM states: LOSS, ACQ, LOCKED; an internal cand_off register and a hit counter cnt shall be kept.
REQ-017 LOSS, any hit: cand_off <= hit_off, cnt <= 1, go to ACQ; no hit: stay.
REQ-018 ACQ, hit at cand_off: cnt increments; if cnt reaches LOCK_CNT, align_offset <= cand_off, cnt <= 0, go to LOCKED.
REQ-019 ACQ, hit only at another offset: cand_off <= hit_off, cnt <= 1, stay in ACQ.
REQ-020 ACQ, no hit: no change.
REQ-021 LOCKED, hit at align_offset: the miss counter shall clear to 0, even if other offsets also hit.
REQ-022 LOCKED, hit only elsewhere: the miss counter increments.
REQ-023 LOCKED, miss counter reaching UNLOCK_CNT: go to ACQ with cand_off <= hit_off and cnt <= 1; align_offset shall be held.
REQ-024 LOCKED, no hit: no change.
REQ-025 align_offset shall change only on entry to LOCKED; the first word at the new offset appears on data_10b one clk after rx_sync's state transition edge.
REQ-026 Counters shall saturate and never wrap; widths shall be sized from LOCK_CNT and UNLOCK_CNT.
REQ-027 data_10b shall be driven in every state; the decoder shall qualify it with rx_sync.

Reset
REQ-028 With reset high at a rising edge, the following shall be 0 after that edge: data_10b, comma, rx_sync, align_offset, prev_raw, cand_off, cnt and the miss counter.
REQ-029 The FSM shall be in LOSS after reset.
REQ-030 Reset shall take priority over all FSM activity, including mid-ACQ and mid-LOCKED.

Structure
REQ-031 A shared package shall hold the comma patterns (0011111, 1100000), the FSM state encoding and the K28.5 code-groups (0011111010, 1100000101).
REQ-032 A combinational sub-module comma_detect shall take the 20-bit history and output a 10-bit hit vector, an any-hit flag and the priority-encoded hit_off.

Verification
REQ-033 Reset, then alternating K28.5 (0011111010/1100000101) at offset 0 -> rx_sync=1 after the 3rd comma; align_offset=0; data_10b equals raw delayed 2 clks.
REQ-034 The same stream skewed by 3 bits -> align_offset=3; data_10b shows 0011111010/1100000101; comma=1 on those words.
REQ-035 In ACQ, 2 commas at offset 3 then a comma at offset 5 -> cnt restarts; lock at offset 5 after 2 further commas at 5.
REQ-036 Locked at 3, 4 consecutive commas at offset 6 -> rx_sync falls; state ACQ with cand_off 6 and align_offset held at 3.
REQ-037 Locked at 3, 3 commas at offset 6, then one at offset 3 -> rx_sync stays 1 and the miss counter is 0.
REQ-038 Reset asserted one clk while LOCKED -> all outputs 0 on the next edge; relock requires 3 fresh commas.
